word_stream_loader: RTL and testbench

//   Byte-to-word deserializer and memory loader: the write-side counterpart of the

---
 rtl/word_stream_if.sv | 22 ++
 rtl/word_stream_loader.sv | 108 ++++++++++
 tb/tb_word_stream_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/word_stream_if.sv
// Byte-stream handshake and RAM write bus shared by the loader and its neighbours.
// The slave modport is the loader side; master is the byte source / RAM side.
interface word_stream_if #(
    parameter int ADDR_W = 5
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_data
    );

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/word_stream_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them
// to program RAM at an auto-incrementing, wrapping address.
module word_stream_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              flush,
    word_stream_if.slave      bus,
    output logic              busy,
    output logic [ADDR_W:0]   word_count,
    output logic              wrapped
);
    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [1:0]        idx;
    logic [31:0]       data;
    logic              flush_pend;
    logic              accept;
    logic [2:0]        fill;
    logic [ADDR_W-1:0] start_ptr;

    // Extra bit lets DEPTH == 2**ADDR_W be represented in the modulo.
    assign start_ptr = ADDR_W'({1'b0, start_addr} % (ADDR_W+1)'(DEPTH));

    assign accept = bus.byte_valid && (state == COLLECT);
    assign fill   = {1'b0, idx} + {2'b00, accept};

    always_comb begin
        state_nx       = state;
        bus.byte_ready = 1'b0;
        bus.mem_we     = 1'b0;
        busy           = 1'b0;
        unique case (state)
            IDLE: begin
                state_nx = IDLE;
            end
            COLLECT: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
                if (fill == 3'd4)
                    state_nx = WRITE;
                else if (flush)
                    state_nx = (fill != 3'd0) ? WRITE : IDLE;
            end
            WRITE: begin
                bus.mem_we = 1'b1;
                busy       = 1'b1;
                state_nx   = flush_pend ? IDLE : COLLECT;
            end
            default: state_nx = IDLE;
        endcase
        if (start)
            state_nx = COLLECT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            idx        <= '0;
            data       <= '0;
            flush_pend <= 1'b0;
            word_count <= '0;
            wrapped    <= 1'b0;
        end else begin
            state <= state_nx;
            if (start) begin
                ptr        <= start_ptr;
                idx        <= '0;
                data       <= '0;
                flush_pend <= 1'b0;
                word_count <= '0;
                wrapped    <= 1'b0;
            end else if (state == COLLECT) begin
                if (accept) begin
                    data[8*idx +: 8] <= bus.byte_in;
                    idx              <= idx + 2'd1;
                end
                flush_pend <= flush;
            end else if (state == WRITE) begin
                data       <= '0;
                idx        <= '0;
                flush_pend <= 1'b0;
                if (word_count != '1)
                    word_count <= word_count + 1'b1;
                if (ptr == ADDR_W'(DEPTH - 1)) begin
                    ptr     <= '0;
                    wrapped <= 1'b1;
                end else begin
                    ptr <= ptr + 1'b1;
                end
            end
        end
    end

    assign bus.mem_addr = ptr;
    assign bus.mem_data = data;
endmodule

// File: tb/tb_word_stream_loader.sv
// Randomized and directed checks of word_stream_loader against a
// byte-packing memory model.
module tb_word_stream_loader;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic              flush = 1'b0;
    logic              busy;
    logic [ADDR_W:0]   word_count;
    logic              wrapped;

    int vecs = 0;
    int errs = 0;
    int stalls = 0;

    logic [36:0] wq[$];
    logic [31:0] dut_mem[DEPTH];
    logic [31:0] ref_mem[DEPTH];

    word_stream_if #(.ADDR_W(ADDR_W)) bus ();

    word_stream_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .start_addr(start_addr),
        .flush(flush),
        .bus(bus),
        .busy(busy),
        .word_count(word_count),
        .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_we) begin
            wq.push_back({bus.mem_addr, bus.mem_data});
            dut_mem[bus.mem_addr] = bus.mem_data;
        end
    end

    task automatic chk(input string tag, input logic [36:0] got, input logic [36:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] a);
        start      = 1'b1;
        start_addr = a;
        tick();
        start = 1'b0;
    endtask

    // Present a byte until it is accepted; leaves byte_valid high.
    task automatic push_byte(input logic [7:0] b);
        bit done = 0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (bus.byte_ready) done = 1;
            else stalls++;
            tick();
        end
        if (!done) chk("push_timeout", 37'd0, 37'd1);
    endtask

    initial begin
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;
        tick();
        tick();
        chk("rst_ready", bus.byte_ready, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_data", bus.mem_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", word_count, 0);
        chk("rst_wrapped", wrapped, 0);
        rst = 1'b0;
        tick();

        // single word
        do_start(0);
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        bus.byte_valid = 1'b0;
        chk("t1_we", bus.mem_we, 1);
        chk("t1_addr", bus.mem_addr, 0);
        chk("t1_data", bus.mem_data, 32'h44332211);
        chk("t1_ready", bus.byte_ready, 0);
        tick();
        chk("t1_we_off", bus.mem_we, 0);
        chk("t1_count", word_count, 1);

        // 8 bytes with valid held high
        do_start(0);
        wq.delete();
        stalls = 0;
        for (int i = 0; i < 8; i++) push_byte(8'(8'h50 + i));
        bus.byte_valid = 1'b0;
        tick();
        tick();
        chk("t2_nwrites", wq.size(), 2);
        chk("t2_stalls", stalls, 1);
        if (wq.size() == 2) begin
            chk("t2_w0", wq[0], {5'd0, 32'h53525150});
            chk("t2_w1", wq[1], {5'd1, 32'h57565554});
        end

        // wrap 31 -> 0
        do_start(31);
        wq.delete();
        for (int i = 0; i < 5; i++) push_byte(8'(i + 1));
        chk("t3_wrapped", wrapped, 1);
        chk("t3_ptr0", bus.mem_addr, 0);
        for (int i = 5; i < 8; i++) push_byte(8'(i + 1));
        bus.byte_valid = 1'b0;
        tick();
        chk("t3_nwrites", wq.size(), 2);
        if (wq.size() == 2) begin
            chk("t3_w0", wq[0], {5'd31, 32'h04030201});
            chk("t3_w1", wq[1], {5'd0, 32'h08070605});
        end
        do_start(5);
        chk("t3_clr_wrapped", wrapped, 0);
        chk("t3_new_ptr", bus.mem_addr, 5);

        // flush paths
        do_start(0);
        push_byte(8'hAA);
        push_byte(8'hBB);
        bus.byte_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_we", bus.mem_we, 1);
        chk("t4_data", bus.mem_data, 32'h0000BBAA);
        tick();
        chk("t4_idle", busy, 0);
        do_start(0);
        push_byte(8'hAA);
        push_byte(8'hBB);
        bus.byte_in = 8'hCC;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.byte_valid = 1'b0;
        chk("t4c_we", bus.mem_we, 1);
        chk("t4c_data", bus.mem_data, 32'h00CCBBAA);
        tick();
        chk("t4c_idle", busy, 0);
        do_start(0);
        wq.delete();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4e_we", bus.mem_we, 0);
        chk("t4e_idle", busy, 0);
        tick();
        chk("t4e_nwrites", wq.size(), 0);

        // start beats flush
        do_start(3);
        wq.delete();
        push_byte(8'h01);
        push_byte(8'h02);
        bus.byte_valid = 1'b0;
        start      = 1'b1;
        start_addr = 9;
        flush      = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        chk("t5_we", bus.mem_we, 0);
        chk("t5_ptr", bus.mem_addr, 9);
        chk("t5_data", bus.mem_data, 0);
        chk("t5_busy", busy, 1);
        push_byte(8'h7E);
        bus.byte_valid = 1'b0;
        chk("t5_lane0", bus.mem_data, 32'h0000007E);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_data", bus.mem_data, 0);
        chk("t5_rst_addr", bus.mem_addr, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ready", bus.byte_ready, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t5_nwrites", wq.size(), 0);

        // randomized gaps over a full image
        for (int w = 0; w < DEPTH; w++) begin
            ref_mem[w] = '0;
            dut_mem[w] = 32'hDEADBEEF;
        end
        do_start(0);
        for (int w = 0; w < DEPTH; w++) begin
            for (int k = 0; k < 4; k++) begin
                logic [7:0] b;
                b = 8'($urandom);
                bus.byte_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
                push_byte(b);
                ref_mem[w] = ref_mem[w] | (32'(b) << (8 * k));
            end
        end
        bus.byte_valid = 1'b0;
        tick();
        tick();
        for (int w = 0; w < DEPTH; w++)
            chk($sformatf("t6_mem%0d", w), dut_mem[w], ref_mem[w]);
        chk("t6_count", word_count, DEPTH);
        chk("t6_wrapped", wrapped, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
